// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions used by the encoder/transmitter and the decoder.
package hamming_pkg;

   localparam int WIDTH_DATA = 4;
   localparam int WIDTH_CODE = 7;

   // Codeword bit positions of the data and parity bits
   localparam int IDX_D0 = 2;
   localparam int IDX_D1 = 4;
   localparam int IDX_D2 = 5;
   localparam int IDX_D3 = 6;
   localparam int IDX_P0 = 0;
   localparam int IDX_P1 = 1;
   localparam int IDX_P2 = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } tx_state_e;

   function automatic logic [6:0] hamming_encode(input logic [3:0] d);
      logic [6:0] c;
      c         = 7'd0;
      c[IDX_D0] = d[0];
      c[IDX_D1] = d[1];
      c[IDX_D2] = d[2];
      c[IDX_D3] = d[3];
      c[IDX_P0] = d[0] ^ d[1] ^ d[3];
      c[IDX_P1] = d[0] ^ d[2] ^ d[3];
      c[IDX_P2] = d[1] ^ d[2] ^ d[3];
      return c;
   endfunction

endpackage

// File: rtl/hamming_piso_load.sv
// 7-bit parallel-load / shift-left register presenting its MSB as the next serial bit.
module hamming_piso_load
   import hamming_pkg::*;
#(
   parameter logic FILL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       shift_i,
   input  logic [6:0] data_i,
   output logic       msb_o
);

   logic [6:0] shreg_q;
   logic [6:0] shreg_d;

   // Next-state selection: load has priority over shift
   always_comb begin
      shreg_d = shreg_q;
      if (load_i) begin
         shreg_d = data_i;
      end else if (shift_i) begin
         shreg_d = {shreg_q[5:0], FILL};
      end else begin
         shreg_d = shreg_q;
      end
   end

   // Shift register state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_q <= 7'd0;
      end else begin
         shreg_q <= shreg_d;
      end
   end

   assign msb_o = shreg_q[6];

endmodule

// File: rtl/hamming_encoder_tx.sv
// Hamming(7,4) encoder with valid/ready input, optional single-bit error injection
// and MSB-first serialisation of each codeword onto a registered serial link.
module hamming_encoder_tx
   import hamming_pkg::*;
#(
   parameter int   WIDTH_DATA = 4,
   parameter int   WIDTH_CODE = 7,
   parameter int   GAP_CYCLES = 0,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH_DATA-1:0] data_in,
   input  logic                  data_valid,
   output logic                  data_ready,
   input  logic                  err_en,
   input  logic [2:0]            err_pos,
   output logic                  serial_out,
   output logic                  serial_valid,
   output logic                  frame_start,
   output logic [WIDTH_CODE-1:0] codeword,
   output logic                  busy
);

   tx_state_e  state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [3:0] gap_q, gap_d;
   logic [6:0] codeword_q, codeword_d;
   logic       serial_out_q, serial_out_d;
   logic       serial_valid_q, serial_valid_d;
   logic       frame_start_q, frame_start_d;
   logic       busy_q, busy_d;

   logic       data_ready_s;
   logic       accept_s;
   logic [6:0] cw_enc_s;
   logic [6:0] flip_mask_s;
   logic [6:0] cw_inj_s;
   logic       load_s;
   logic       shift_s;
   logic       next_bit_s;

   assign cw_enc_s    = hamming_encode(data_in);
   assign flip_mask_s = (err_en && (err_pos != 3'd7)) ? (7'd1 << err_pos) : 7'd0;
   assign cw_inj_s    = cw_enc_s ^ flip_mask_s;
   assign accept_s    = data_valid && data_ready_s;

   // Ready decode: idle, or last bit of a frame when frames may run back to back
   always_comb begin
      data_ready_s = 1'b0;
      case (state_q)
         IDLE:    data_ready_s = 1'b1;
         SHIFT:   data_ready_s = (cnt_q == 3'd6) && (GAP_CYCLES == 0);
         GAP:     data_ready_s = 1'b0;
         default: data_ready_s = 1'b0;
      endcase
   end

   // cw[6] goes straight to serial_out, so the shift register is preloaded one bit ahead
   hamming_piso_load #(
      .FILL(IDLE_LEVEL)
   ) u_piso (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load_s),
      .shift_i(shift_s),
      .data_i ({cw_inj_s[5:0], IDLE_LEVEL}),
      .msb_o  (next_bit_s)
   );

   // FSM next state and next values of the registered outputs
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      gap_d          = gap_q;
      codeword_d     = codeword_q;
      load_s         = 1'b0;
      shift_s        = 1'b0;
      serial_out_d   = IDLE_LEVEL;
      serial_valid_d = 1'b0;
      frame_start_d  = 1'b0;
      if (accept_s) begin
         state_d        = SHIFT;
         cnt_d          = 3'd0;
         load_s         = 1'b1;
         codeword_d     = cw_inj_s;
         serial_out_d   = cw_inj_s[6];
         serial_valid_d = 1'b1;
         frame_start_d  = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = IDLE;
            end
            SHIFT: begin
               if (cnt_q == 3'd6) begin
                  cnt_d = 3'd0;
                  gap_d = 4'd0;
                  if (GAP_CYCLES == 0) begin
                     state_d = IDLE;
                  end else begin
                     state_d = GAP;
                  end
               end else begin
                  cnt_d          = cnt_q + 3'd1;
                  shift_s        = 1'b1;
                  serial_out_d   = next_bit_s;
                  serial_valid_d = 1'b1;
               end
            end
            GAP: begin
               if (gap_q == 4'(GAP_CYCLES - 1)) begin
                  state_d = IDLE;
                  gap_d   = 4'd0;
               end else begin
                  gap_d = gap_q + 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 3'd0;
               gap_d   = 4'd0;
            end
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= 3'd0;
         gap_q          <= 4'd0;
         codeword_q     <= 7'd0;
         serial_out_q   <= IDLE_LEVEL;
         serial_valid_q <= 1'b0;
         frame_start_q  <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         gap_q          <= gap_d;
         codeword_q     <= codeword_d;
         serial_out_q   <= serial_out_d;
         serial_valid_q <= serial_valid_d;
         frame_start_q  <= frame_start_d;
         busy_q         <= busy_d;
      end
   end

   assign data_ready   = data_ready_s;
   assign serial_out   = serial_out_q;
   assign serial_valid = serial_valid_q;
   assign frame_start  = frame_start_q;
   assign codeword     = codeword_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_hamming_encoder_tx.sv
// Self-checking bench for hamming_encoder_tx: a no-gap instance and a GAP_CYCLES=3 instance,
// checked against a position-numbered Hamming(7,4) reference encoder/decoder.
module tb_hamming_encoder_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] data_in;
   logic       data_valid, data_valid_g;
   logic       err_en;
   logic [2:0] err_pos;

   logic       data_ready, serial_out, serial_valid, frame_start, busy;
   logic [6:0] codeword;
   logic       data_ready_g, serial_out_g, serial_valid_g, frame_start_g, busy_g;
   logic [6:0] codeword_g;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hamming_encoder_tx #(.GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .data_ready(data_ready), .err_en(err_en), .err_pos(err_pos),
      .serial_out(serial_out), .serial_valid(serial_valid), .frame_start(frame_start),
      .codeword(codeword), .busy(busy));

   hamming_encoder_tx #(.GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) dut_g (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid_g),
      .data_ready(data_ready_g), .err_en(err_en), .err_pos(err_pos),
      .serial_out(serial_out_g), .serial_valid(serial_valid_g), .frame_start(frame_start_g),
      .codeword(codeword_g), .busy(busy_g));

   // Reference: Hamming position p (1..7) lives at codeword bit p-1; parity at powers of two
   function automatic logic [6:0] ref_encode(input logic [3:0] d);
      logic [6:0] cw;
      int         dpos[4];
      logic       par;
      dpos[0] = 3; dpos[1] = 5; dpos[2] = 6; dpos[3] = 7;
      cw = 7'd0;
      for (int k = 0; k < 4; k++) cw[dpos[k]-1] = d[k];
      for (int p = 1; p <= 4; p = p * 2) begin
         par = 1'b0;
         for (int pos = 1; pos <= 7; pos++)
            if (((pos & p) != 0) && (pos != p)) par = par ^ cw[pos-1];
         cw[p-1] = par;
      end
      return cw;
   endfunction

   function automatic logic [6:0] ref_inject(input logic [6:0] cw, input logic e, input logic [2:0] p);
      logic [6:0] r;
      r = cw;
      if (e && (p < 3'd7)) r[p] = ~r[p];
      return r;
   endfunction

   function automatic int ref_syndrome(input logic [6:0] cw);
      int s;
      s = 0;
      for (int i = 0; i < 7; i++) if (cw[i]) s = s ^ (i + 1);
      return s;
   endfunction

   function automatic logic [3:0] ref_decode(input logic [6:0] cw);
      logic [6:0] c;
      int         s;
      c = cw;
      s = ref_syndrome(cw);
      if (s != 0) c[s-1] = ~c[s-1];
      return {c[6], c[5], c[4], c[2]};
   endfunction

   task automatic send_frame(input logic [3:0] d, input logic e, input logic [2:0] p,
                             output logic [6:0] rx);
      logic [6:0] exp;
      int         n;
      exp = ref_inject(ref_encode(d), e, p);
      @(negedge clk);
      data_in = d; err_en = e; err_pos = p; data_valid = 1'b1;
      n = 0;
      while (data_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= 40) begin
         n_err++;
         $display("FAIL ready_timeout got=%b want=1", data_ready);
      end
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      data_in = 4'($urandom); err_en = 1'($urandom); err_pos = 3'($urandom);
      rx = 7'd0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         rx[6-i] = serial_out;
         n_cmp++;
         if (serial_valid !== 1'b1 || serial_out !== exp[6-i] || frame_start !== 1'(i == 0)) begin
            n_err++;
            $display("FAIL serial_bit%0d got v=%b b=%b fs=%b want v=1 b=%b fs=%b",
                     i, serial_valid, serial_out, frame_start, exp[6-i], 1'(i == 0));
         end
      end
      n_cmp++;
      if (codeword !== exp) begin
         n_err++;
         $display("FAIL codeword got=%b want=%b", codeword, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      n_cmp++;
      if (serial_out !== 1'b0 || serial_valid !== 1'b0 || frame_start !== 1'b0 ||
          busy !== 1'b0 || data_ready !== 1'b1 || codeword !== 7'd0) begin
         n_err++;
         $display("FAIL %s got so=%b sv=%b fs=%b busy=%b rdy=%b cw=%b want 0 0 0 0 1 0000000",
                  tag, serial_out, serial_valid, frame_start, busy, data_ready, codeword);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; data_valid = 1'b1; data_valid_g = 1'b1; data_in = 4'hF;
      err_en = 1'b0; err_pos = 3'd7;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset_main");
      n_cmp++;
      if (serial_valid_g !== 1'b0 || busy_g !== 1'b0 || data_ready_g !== 1'b1 || codeword_g !== 7'd0) begin
         n_err++;
         $display("FAIL reset_gap got sv=%b busy=%b rdy=%b cw=%b want 0 0 1 0000000",
                  serial_valid_g, busy_g, data_ready_g, codeword_g);
      end
      data_valid = 1'b0; data_valid_g = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_values("after_release");
   endtask

   task automatic test_basic();
      logic [6:0] rx;
      send_frame(4'b1011, 1'b0, 3'd7, rx);
      n_cmp++;
      if (rx !== 7'b1010101) begin
         n_err++;
         $display("FAIL basic_1011 got=%b want=1010101", rx);
      end
      @(negedge clk);
      n_cmp++;
      if (serial_valid !== 1'b0 || serial_out !== 1'b0 || busy !== 1'b0 || data_ready !== 1'b1) begin
         n_err++;
         $display("FAIL basic_idle got sv=%b so=%b busy=%b rdy=%b want 0 0 0 1",
                  serial_valid, serial_out, busy, data_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] e0, e1;
      logic       eb;
      e0 = ref_encode(4'b0000);
      e1 = ref_encode(4'b1111);
      @(negedge clk);
      data_in = 4'b0000; err_en = 1'b0; err_pos = 3'd7; data_valid = 1'b1;
      @(posedge clk);
      #1 data_in = 4'b1111;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         eb = (i < 7) ? e0[6-i] : e1[13-i];
         n_cmp++;
         if (serial_valid !== 1'b1 || serial_out !== eb || busy !== 1'b1 ||
             frame_start !== 1'(i == 0 || i == 7) || data_ready !== 1'(i == 6 || i == 13)) begin
            n_err++;
            $display("FAIL b2b_cycle%0d got v=%b b=%b fs=%b rdy=%b busy=%b want v=1 b=%b fs=%b rdy=%b busy=1",
                     i, serial_valid, serial_out, frame_start, data_ready, busy,
                     eb, 1'(i == 0 || i == 7), 1'(i == 6 || i == 13));
         end
         if (i == 6) begin
            @(posedge clk);
            #1 data_valid = 1'b0;
         end
      end
      @(negedge clk);
      n_cmp++;
      if (serial_valid !== 1'b0 || busy !== 1'b0 || codeword !== 7'b1111111) begin
         n_err++;
         $display("FAIL b2b_end got sv=%b busy=%b cw=%b want 0 0 1111111", serial_valid, busy, codeword);
      end
   endtask

   task automatic test_decoder_loop();
      logic [6:0] rx;
      send_frame(4'b0001, 1'b0, 3'd7, rx);
      n_cmp++;
      if (rx !== 7'b0000111 || ref_syndrome(rx) != 0 || ref_decode(rx) !== 4'b0001) begin
         n_err++;
         $display("FAIL loop_0001 got cw=%b syn=%0d dec=%b want 0000111 0 0001",
                  rx, ref_syndrome(rx), ref_decode(rx));
      end
      send_frame(4'b1011, 1'b1, 3'd5, rx);
      n_cmp++;
      if (rx !== 7'b1110101 || ref_syndrome(rx) != 6 || ref_decode(rx) !== 4'b1011) begin
         n_err++;
         $display("FAIL inject_pos5 got cw=%b syn=%0d dec=%b want 1110101 6 1011",
                  rx, ref_syndrome(rx), ref_decode(rx));
      end
      send_frame(4'b1011, 1'b1, 3'd7, rx);
      n_cmp++;
      if (rx !== 7'b1010101) begin
         n_err++;
         $display("FAIL inject_pos7 got=%b want=1010101", rx);
      end
   endtask

   task automatic test_random();
      logic [6:0] rx;
      logic [3:0] d;
      logic       e;
      logic [2:0] p;
      for (int k = 0; k < 24; k++) begin
         d = 4'($urandom); e = 1'($urandom); p = 3'($urandom);
         send_frame(d, e, p, rx);
         n_cmp++;
         if (ref_decode(rx) !== d) begin
            n_err++;
            $display("FAIL random_decode%0d got=%b want=%b (e=%b p=%0d)", k, ref_decode(rx), d, e, p);
         end
      end
   endtask

   task automatic test_gap();
      logic [3:0] d0, d1;
      logic [6:0] e0, e1;
      logic [13:0] bits;
      int nbits, frames, both_low, i;
      d0 = 4'($urandom); d1 = 4'($urandom);
      e0 = ref_encode(d0); e1 = ref_encode(d1);
      nbits = 0; frames = 0; both_low = 0; bits = 14'd0;
      @(negedge clk);
      data_in = d0; err_en = 1'b0; err_pos = 3'd7; data_valid_g = 1'b1;
      @(posedge clk);
      #1 data_in = d1;
      i = 0;
      while (i < 60 && !(frames == 2 && nbits >= 14)) begin
         @(negedge clk);
         if (frame_start_g) begin
            frames++;
            if (frames == 2) data_valid_g = 1'b0;
         end
         if (serial_valid_g && nbits < 14) begin
            bits[13-nbits] = serial_out_g;
            nbits++;
         end
         if (frames == 1 && nbits == 7 && !serial_valid_g && !data_ready_g) both_low++;
         i++;
      end
      data_valid_g = 1'b0;
      n_cmp++;
      if (nbits != 14 || frames != 2) begin
         n_err++;
         $display("FAIL gap_frames got bits=%0d frames=%0d want 14 2", nbits, frames);
      end
      n_cmp++;
      if (both_low != 3) begin
         n_err++;
         $display("FAIL gap_len got=%0d want=3", both_low);
      end
      n_cmp++;
      if (bits !== {e0, e1}) begin
         n_err++;
         $display("FAIL gap_bits got=%b want=%b", bits, {e0, e1});
      end
   endtask

   task automatic test_reset_midframe();
      logic [6:0] rx;
      @(negedge clk);
      data_in = 4'b1011; err_en = 1'b0; err_pos = 3'd7; data_valid = 1'b1;
      @(posedge clk);
      #1 data_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_values("midframe_reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (serial_valid !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL no_resume got sv=%b busy=%b want 0 0", serial_valid, busy);
      end
      send_frame(4'($urandom), 1'b0, 3'd7, rx);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_decoder_loop();
      test_random();
      test_gap();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
